lvl1_sig: RTL and testbench

LVL1_SIG -- requirements
Module: lvl1_sig

---
 rtl/lvl1_sig.sv | 107 ++++++++++
 tb/tb_lvl1_sig.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvl1_sig.sv
// Serial signature compactor for the lvl1 test stage output.
// Captures WIN din samples into an LFSR signature and a ones count.
module lvl1_sig #(
  parameter int unsigned WIN  = 64,
  parameter logic [15:0] SEED = 16'h0000,
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        start,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig,
  output logic [7:0]  ones
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [7:0] LAST = 8'(WIN - 1);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  ones_q, ones_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sig_shift;

  always_comb begin
    sig_shift = {sig_q[14:0], 1'b0}
              ^ (sig_q[15] ? POLY : 16'h0000)
              ^ {15'b0, din};
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          sig_d   = SEED;
          ones_d  = 8'h00;
          cnt_d   = 8'h00;
        end
      end
      RUN: begin
        sig_d = sig_shift;
        cnt_d = cnt_q + 8'd1;
        if (din && ones_q != 8'hFF)
          ones_d = ones_q + 8'd1;
        // done rises on the edge that takes the final sample
        if (cnt_q == LAST) begin
          state_d = HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SEED;
      ones_q  <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sig  = sig_q;
  assign ones = ones_q;

endmodule

// File: tb/tb_lvl1_sig.sv
// Directed bench for lvl1_sig: vector table plus
// hand-written multi-cycle corner sequences.
module tb_lvl1_sig;

  logic clk = 1'b0;
  logic rst;

  logic s4, a4, d4, b4, dn4;
  logic [15:0] sg4;
  logic [7:0]  on4;

  logic s1, a1, d1, b1, dn1;
  logic [15:0] sg1;
  logic [7:0]  on1;

  logic s255, a255, d255, b255, dn255;
  logic [15:0] sg255;
  logic [7:0]  on255;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lvl1_sig #(.WIN(4), .SEED(16'h0000), .POLY(16'h1021)) u4 (
    .clk(clk), .rst(rst), .din(d4), .start(s4), .ack(a4),
    .busy(b4), .done(dn4), .sig(sg4), .ones(on4)
  );

  lvl1_sig #(.WIN(1), .SEED(16'h8000), .POLY(16'h1021)) u1 (
    .clk(clk), .rst(rst), .din(d1), .start(s1), .ack(a1),
    .busy(b1), .done(dn1), .sig(sg1), .ones(on1)
  );

  lvl1_sig #(.WIN(255), .SEED(16'h0000), .POLY(16'h1021)) u255 (
    .clk(clk), .rst(rst), .din(d255), .start(s255), .ack(a255),
    .busy(b255), .done(dn255), .sig(sg255), .ones(on255)
  );

  typedef struct {
    logic [3:0]  bits;
    logic [15:0] sig;
    logic [7:0]  ones;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // bits[3] is the first sample
  task automatic run4(input logic [3:0] bits);
    s4 = 1'b1;
    step;
    s4 = 1'b0;
    chk("run4 busy", 32'(b4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      d4 = bits[3-i];
      if (i == 3) chk("run4 done early", 32'(dn4), 32'd0);
      step;
    end
    d4 = 1'b0;
    chk("run4 done", 32'(dn4), 32'd1);
    chk("run4 busy end", 32'(b4), 32'd0);
  endtask

  task automatic ack4;
    a4 = 1'b1;
    step;
    a4 = 1'b0;
    chk("ack4 done", 32'(dn4), 32'd0);
  endtask

  initial begin
    int n;
    vt[0] = '{4'b1000, 16'h0008, 8'd1};
    vt[1] = '{4'b1111, 16'h000F, 8'd4};
    vt[2] = '{4'b0000, 16'h0000, 8'd0};
    vt[3] = '{4'b1010, 16'h000A, 8'd2};
    vt[4] = '{4'b0001, 16'h0001, 8'd1};

    rst = 1'b0;
    {s4, a4, d4, s1, a1, d1, s255, a255, d255} = '0;
    #22;
    chk("rst busy", 32'(b4), 32'd0);
    chk("rst done", 32'(dn4), 32'd0);
    chk("rst sig4", 32'(sg4), 32'h0);
    chk("rst ones4", 32'(on4), 32'h0);
    chk("rst sig1", 32'(sg1), 32'h8000);
    rst = 1'b1;
    step;
    d4 = 1'b1;
    step;
    chk("idle din ignored", 32'(on4), 32'h0);
    d4 = 1'b0;

    for (int k = 0; k < 5; k++) begin
      run4(vt[k].bits);
      chk("vec sig", 32'(sg4), 32'(vt[k].sig));
      chk("vec ones", 32'(on4), 32'(vt[k].ones));
      ack4;
      chk("vec sig kept", 32'(sg4), 32'(vt[k].sig));
      chk("vec ones kept", 32'(on4), 32'(vt[k].ones));
    end

    run4(4'b1111);
    for (int k = 0; k < 10; k++) begin
      s4 = 1'b1;
      d4 = ~d4;
      step;
      chk("hold done", 32'(dn4), 32'd1);
      chk("hold sig", 32'(sg4), 32'h000F);
      chk("hold ones", 32'(on4), 32'd4);
    end
    s4 = 1'b0;
    d4 = 1'b0;
    ack4;

    a4 = 1'b1;
    step;
    a4 = 1'b0;
    chk("idle ack busy", 32'(b4), 32'd0);
    chk("idle ack done", 32'(dn4), 32'd0);

    s1 = 1'b1;
    step;
    s1 = 1'b0;
    d1 = 1'b0;
    step;
    chk("win1 done", 32'(dn1), 32'd1);
    chk("win1 sig", 32'(sg1), 32'h1021);
    chk("win1 ones", 32'(on1), 32'd0);
    a1 = 1'b1;
    step;
    a1 = 1'b0;

    s4 = 1'b1;
    step;
    s4 = 1'b0;
    d4 = 1'b1;
    step;
    s4 = 1'b1;
    step;
    s4 = 1'b0;
    step;
    chk("midrun no done", 32'(dn4), 32'd0);
    step;
    d4 = 1'b0;
    chk("midrun done", 32'(dn4), 32'd1);
    chk("midrun sig", 32'(sg4), 32'h000F);
    a4 = 1'b1;
    s4 = 1'b1;
    step;
    a4 = 1'b0;
    s4 = 1'b0;
    chk("ack+start done", 32'(dn4), 32'd0);
    chk("ack+start busy", 32'(b4), 32'd0);
    step;
    chk("no restart busy", 32'(b4), 32'd0);
    run4(4'b0001);
    chk("fresh sig", 32'(sg4), 32'h0001);
    chk("fresh ones", 32'(on4), 32'd1);
    ack4;

    s4 = 1'b1;
    step;
    s4 = 1'b0;
    d4 = 1'b1;
    step;
    d4 = 1'b1;
    step;
    #3;
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(b4), 32'd0);
    chk("abort done", 32'(dn4), 32'd0);
    chk("abort sig", 32'(sg4), 32'h0);
    chk("abort ones", 32'(on4), 32'd0);
    chk("abort sig1", 32'(sg1), 32'h8000);
    rst = 1'b1;
    d4 = 1'b0;
    step;
    chk("post rst idle", 32'(b4), 32'd0);
    run4(4'b1000);
    chk("post rst sig", 32'(sg4), 32'h0008);
    chk("post rst ones", 32'(on4), 32'd1);
    ack4;

    d255 = 1'b1;
    s255 = 1'b1;
    step;
    s255 = 1'b0;
    n = 1;
    while (!dn255 && n < 400) begin
      step;
      n++;
    end
    chk("win255 edges", 32'(n), 32'd256);
    chk("win255 ones", 32'(on255), 32'hFF);
    chk("win255 busy", 32'(b255), 32'd0);
    d255 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
